// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/interrupt sequencing between the WB stage and the CSR file.
// Each RUN cycle it arbitrates the WB instruction's exception flags against pending
// interrupts and ERTN, issues a single-cycle commit pulse to the CSR file, flushes
// the pipeline, and holds the IF redirect until IF accepts it. It also owns the
// constant timer (TCFG/TVAL) and the timer-interrupt pending bit ESTAT.IS[11].
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   wb_valid/wb_pc/wb_exc/wb_ertn  WB instruction info; wb_exc = {ALE,BRK,SYS,INE,ADEF}
//   hw_int, sw_int              interrupt sources (ESTAT.IS[9:2], IS[1:0])
//   crmd_ie, ecfg_lie           global and per-line interrupt enables
//   tcfg_we/tcfg_wdata          TCFG write {InitVal, Periodic, En}
//   ticlr_we                    TICLR write with bit0 = 1
//   tval, ti_pend               timer value and timer-interrupt pending
//   exc_signal/ertn_signal      one-cycle commit pulses
//   exc_ecode/exc_esubcode/exc_pc  exception info, held outside the pulse cycle
//   flush                       kill all pipeline stages
//   redirect_valid/redirect_ready  IF redirect handshake
module exc_ctrl #(
  parameter int unsigned TIMER_W = 32,
  parameter int unsigned HWI_W   = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               wb_valid,
  input  logic [31:0]        wb_pc,
  input  logic [4:0]         wb_exc,
  input  logic               wb_ertn,
  input  logic [HWI_W-1:0]   hw_int,
  input  logic [1:0]         sw_int,
  input  logic               crmd_ie,
  input  logic [12:0]        ecfg_lie,
  input  logic               tcfg_we,
  input  logic [31:0]        tcfg_wdata,
  input  logic               ticlr_we,
  output logic [TIMER_W-1:0] tval,
  output logic               ti_pend,
  output logic               exc_signal,
  output logic               ertn_signal,
  output logic [5:0]         exc_ecode,
  output logic [8:0]         exc_esubcode,
  output logic [31:0]        exc_pc,
  output logic               flush,
  output logic               redirect_valid,
  input  logic               redirect_ready
);

  localparam logic [5:0]  ECODE_INT  = 6'h00;
  localparam logic [5:0]  ECODE_ADEF = 6'h08;
  localparam logic [5:0]  ECODE_ALE  = 6'h09;
  localparam logic [5:0]  ECODE_SYS  = 6'h0B;
  localparam logic [5:0]  ECODE_BRK  = 6'h0C;
  localparam logic [5:0]  ECODE_INE  = 6'h0D;
  // Only IS bits 11 and 9:0 exist as interrupt sources.
  localparam logic [12:0] IS_MASK    = 13'h0BFF;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [12:0]  is_vec;
  logic         int_pend;
  logic [5:0]   sel_ecode;
  logic [5:0]   ecode_q;
  logic [31:0]  pc_q;
  logic [31:0]  tcfg_q;
  logic         tmr_en;
  logic         tmr_periodic;
  logic         tmr_expire;

  // Assemble ESTAT.IS from the live sources and reduce against the enables.
  always_comb begin
    is_vec              = '0;
    is_vec[1:0]         = sw_int;
    is_vec[2 +: HWI_W]  = hw_int;
    is_vec[11]          = ti_pend;
    int_pend            = (|(is_vec & ecfg_lie & IS_MASK)) & crmd_ie;
  end

  // Fixed-priority exception code select; INT outranks every synchronous exception.
  always_comb begin
    sel_ecode = ECODE_ALE;
    if (int_pend)       sel_ecode = ECODE_INT;
    else if (wb_exc[0]) sel_ecode = ECODE_ADEF;
    else if (wb_exc[1]) sel_ecode = ECODE_INE;
    else if (wb_exc[2]) sel_ecode = ECODE_SYS;
    else if (wb_exc[3]) sel_ecode = ECODE_BRK;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_RUN;
    else         state <= state_nxt;
  end

  // Next state and control outputs; reset forces every output low.
  always_comb begin
    state_nxt      = state;
    exc_signal     = 1'b0;
    ertn_signal    = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    case (state)
      S_RUN: begin
        if (wb_valid && (int_pend || (|wb_exc))) begin
          exc_signal = 1'b1;
          flush      = 1'b1;
          state_nxt  = S_FLUSH;
        end else if (wb_valid && wb_ertn) begin
          ertn_signal = 1'b1;
          flush       = 1'b1;
          state_nxt   = S_FLUSH;
        end
      end
      S_FLUSH: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        state_nxt      = redirect_ready ? S_RUN : S_WAIT;
      end
      S_WAIT: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        if (redirect_ready) state_nxt = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
    if (!resetn) begin
      exc_signal     = 1'b0;
      ertn_signal    = 1'b0;
      flush          = 1'b0;
      redirect_valid = 1'b0;
    end
  end

  // Hold the last committed exception info between pulses.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ecode_q <= '0;
      pc_q    <= '0;
    end else if (exc_signal) begin
      ecode_q <= sel_ecode;
      pc_q    <= wb_pc;
    end
  end

  assign exc_ecode    = exc_signal ? sel_ecode : ecode_q;
  assign exc_pc       = exc_signal ? wb_pc : pc_q;
  assign exc_esubcode = 9'd0;

  assign tmr_en       = tcfg_q[0];
  assign tmr_periodic = tcfg_q[1];
  // The 1 -> 0 step; a same-cycle TCFG write pre-empts it.
  assign tmr_expire   = !tcfg_we && tmr_en && (tval == TIMER_W'(1));

  // Constant timer and its pending bit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tcfg_q  <= '0;
      tval    <= '1;
      ti_pend <= 1'b0;
    end else begin
      if (tcfg_we) begin
        tcfg_q <= tcfg_wdata;
        tval   <= {tcfg_wdata[TIMER_W-1:2], 2'b00};
      end else if (tmr_en && (tval != '0)) begin
        tval <= tval - TIMER_W'(1);
      end else if (tmr_en && tmr_periodic) begin
        // Periodic reload happens one cycle after reaching zero.
        tval <= {tcfg_q[TIMER_W-1:2], 2'b00};
      end
      if (ticlr_we)        ti_pend <= 1'b0;
      else if (tmr_expire) ti_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;

  typedef struct packed {
    logic        ertn;
    logic [5:0]  ecode;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [4:0]  wb_exc;
  logic        wb_ertn;
  logic [7:0]  hw_int;
  logic [1:0]  sw_int;
  logic        crmd_ie;
  logic [12:0] ecfg_lie;
  logic        tcfg_we;
  logic [31:0] tcfg_wdata;
  logic        ticlr_we;
  logic [31:0] tval;
  logic        ti_pend;
  logic        exc_signal;
  logic        ertn_signal;
  logic [5:0]  exc_ecode;
  logic [8:0]  exc_esubcode;
  logic [31:0] exc_pc;
  logic        flush;
  logic        redirect_valid;
  logic        redirect_ready;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  exc_ctrl #(.TIMER_W(32), .HWI_W(8)) dut (
    .clk(clk), .resetn(resetn),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_exc(wb_exc), .wb_ertn(wb_ertn),
    .hw_int(hw_int), .sw_int(sw_int), .crmd_ie(crmd_ie), .ecfg_lie(ecfg_lie),
    .tcfg_we(tcfg_we), .tcfg_wdata(tcfg_wdata), .ticlr_we(ticlr_we),
    .tval(tval), .ti_pend(ti_pend),
    .exc_signal(exc_signal), .ertn_signal(ertn_signal),
    .exc_ecode(exc_ecode), .exc_esubcode(exc_esubcode), .exc_pc(exc_pc),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_ready(redirect_ready)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every commit pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (exc_signal || ertn_signal) begin
      exp_t e;
      checks++;
      if (exc_signal && ertn_signal) begin
        errors++;
        $display("FAIL pulse_both exc_signal=%0b ertn_signal=%0b required one-hot", exc_signal, ertn_signal);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected exc=%0b ertn=%0b ecode=%h required no pulse", exc_signal, ertn_signal, exc_ecode);
      end else begin
        e = exp_q.pop_front();
        if (ertn_signal !== e.ertn ||
            (!e.ertn && (exc_ecode !== e.ecode || exc_pc !== e.pc || exc_esubcode !== 9'd0))) begin
          errors++;
          $display("FAIL pulse_data ertn=%0b ecode=%h pc=%h sub=%h required ertn=%0b ecode=%h pc=%h sub=0",
                   ertn_signal, exc_ecode, exc_pc, exc_esubcode, e.ertn, e.ecode, e.pc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic ertn, input logic [5:0] ecode, input logic [31:0] pc);
    exp_t e;
    e.ertn = ertn; e.ecode = ecode; e.pc = pc;
    exp_q.push_back(e);
  endtask

  // Present one WB instruction, then accept the redirect immediately.
  task automatic fire(input logic [31:0] pc, input logic [4:0] exc, input logic ertn);
    cyc();
    wb_valid = 1'b1; wb_pc = pc; wb_exc = exc; wb_ertn = ertn;
    cyc();
    wb_valid = 1'b0; wb_exc = '0; wb_ertn = 1'b0; redirect_ready = 1'b1;
    cyc();
    redirect_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    wb_valid = 0; wb_pc = '0; wb_exc = '0; wb_ertn = 0; hw_int = '0; sw_int = '0;
    crmd_ie = 0; ecfg_lie = '0; tcfg_we = 0; tcfg_wdata = '0; ticlr_we = 0; redirect_ready = 0;
    cyc(); cyc();
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if ({exc_signal, ertn_signal, flush, redirect_valid, ti_pend} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl exc/ertn/flush/rv/ti=%b required 00000",
               {exc_signal, ertn_signal, flush, redirect_valid, ti_pend});
    end
    checks++;
    if (exc_ecode !== 6'h0 || exc_pc !== 32'h0 || exc_esubcode !== 9'h0) begin
      errors++;
      $display("FAIL reset_info ecode=%h pc=%h sub=%h required 0", exc_ecode, exc_pc, exc_esubcode);
    end
    checks++;
    if (tval !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL reset_tval got=%h required ffffffff", tval);
    end
  endtask

  task automatic test_sys();
    cyc();
    wb_valid = 1'b1; wb_pc = 32'h1c00_0100; wb_exc = 5'b00100;
    push_exp(1'b0, 6'h0B, 32'h1c00_0100);
    @(negedge clk);
    checks++;
    if (flush !== 1'b1 || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL sys_pulse_cycle flush=%0b rv=%0b required 1 0", flush, redirect_valid);
    end
    cyc();
    wb_valid = 1'b0; wb_exc = '0; redirect_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (flush !== 1'b1 || redirect_valid !== 1'b1) begin
      errors++;
      $display("FAIL sys_flush_cycle flush=%0b rv=%0b required 1 1", flush, redirect_valid);
    end
    checks++;
    if (exc_ecode !== 6'h0B || exc_pc !== 32'h1c00_0100) begin
      errors++;
      $display("FAIL sys_hold ecode=%h pc=%h required 0b 1c000100", exc_ecode, exc_pc);
    end
    cyc();
    redirect_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (flush !== 1'b0 || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL sys_back_to_run flush=%0b rv=%0b required 0 0", flush, redirect_valid);
    end
  endtask

  task automatic test_priority();
    push_exp(1'b0, 6'h08, 32'h1c00_0200);
    fire(32'h1c00_0200, 5'b10011, 1'b0);
    push_exp(1'b0, 6'h0D, 32'h1c00_0204);
    fire(32'h1c00_0204, 5'b11110, 1'b1);
    push_exp(1'b0, 6'h0C, 32'h1c00_0208);
    fire(32'h1c00_0208, 5'b11000, 1'b0);
    push_exp(1'b0, 6'h09, 32'h1c00_020c);
    fire(32'h1c00_020c, 5'b10000, 1'b1);
    // Same exceptions with a software interrupt pending: INT wins.
    sw_int = 2'b10; ecfg_lie = 13'h0002; crmd_ie = 1'b1;
    push_exp(1'b0, 6'h00, 32'h1c00_0210);
    fire(32'h1c00_0210, 5'b10011, 1'b0);
    sw_int = '0; ecfg_lie = '0; crmd_ie = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL priority_drain pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_ertn_wait();
    cyc();
    wb_valid = 1'b1; wb_pc = 32'h1c00_0300; wb_ertn = 1'b1;
    push_exp(1'b1, 6'h00, 32'h1c00_0300);
    @(negedge clk);
    checks++;
    if (flush !== 1'b1 || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL ertn_pulse_cycle flush=%0b rv=%0b required 1 0", flush, redirect_valid);
    end
    // wb_ertn stays asserted through FLUSH/WAIT; no second pulse may appear.
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 3) begin
        redirect_ready = 1'b1; wb_valid = 1'b0; wb_ertn = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (flush !== 1'b1 || redirect_valid !== 1'b1) begin
        errors++;
        $display("FAIL ertn_hold_%0d flush=%0b rv=%0b required 1 1", i, flush, redirect_valid);
      end
    end
    cyc();
    redirect_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (flush !== 1'b0 || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL ertn_release flush=%0b rv=%0b required 0 0", flush, redirect_valid);
    end
  endtask

  task automatic test_int_mask();
    cyc();
    hw_int = 8'h01; ecfg_lie = 13'h0004; crmd_ie = 1'b0;
    wb_valid = 1'b1; wb_pc = 32'h1c00_0400;
    @(negedge clk);
    checks++;
    if (exc_signal !== 1'b0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL int_ie_off exc=%0b flush=%0b required 0 0", exc_signal, flush);
    end
    cyc();
    crmd_ie = 1'b1;
    push_exp(1'b0, 6'h00, 32'h1c00_0400);
    @(negedge clk);
    checks++;
    if (exc_signal !== 1'b1) begin
      errors++;
      $display("FAIL int_taken exc=%0b required 1", exc_signal);
    end
    cyc();
    wb_valid = 1'b0; redirect_ready = 1'b1;
    cyc();
    redirect_ready = 1'b0; ecfg_lie = 13'h0000; wb_valid = 1'b1; wb_pc = 32'h1c00_0404;
    @(negedge clk);
    checks++;
    if (exc_signal !== 1'b0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL int_lie_off exc=%0b flush=%0b required 0 0", exc_signal, flush);
    end
    cyc();
    wb_valid = 1'b0; hw_int = '0; crmd_ie = 1'b0;
  endtask

  task automatic test_timer();
    cyc();
    tcfg_we = 1'b1; tcfg_wdata = 32'h0000_000F;   // InitVal 3, Periodic, En
    cyc();
    tcfg_we = 1'b0;
    @(negedge clk);
    checks++;
    if (tval !== 32'd12 || ti_pend !== 1'b0) begin
      errors++;
      $display("FAIL tmr_load tval=%0d ti=%0b required 12 0", tval, ti_pend);
    end
    for (int k = 11; k >= 0; k--) begin
      cyc();
      @(negedge clk);
      checks++;
      if (tval !== 32'(k) || ti_pend !== (k == 0)) begin
        errors++;
        $display("FAIL tmr_count tval=%0d ti=%0b required %0d %0b", tval, ti_pend, k, (k == 0));
      end
    end
    cyc();
    ticlr_we = 1'b1;
    @(negedge clk);
    checks++;
    if (tval !== 32'd12 || ti_pend !== 1'b1) begin
      errors++;
      $display("FAIL tmr_reload tval=%0d ti=%0b required 12 1", tval, ti_pend);
    end
    cyc();
    ticlr_we = 1'b0;
    @(negedge clk);
    checks++;
    if (tval !== 32'd11 || ti_pend !== 1'b0) begin
      errors++;
      $display("FAIL tmr_clear tval=%0d ti=%0b required 11 0", tval, ti_pend);
    end
    for (int k = 10; k >= 1; k--) begin
      cyc();
      if (k == 1) ticlr_we = 1'b1;
    end
    cyc();
    ticlr_we = 1'b0;
    @(negedge clk);
    checks++;
    if (tval !== 32'd0 || ti_pend !== 1'b0) begin
      errors++;
      $display("FAIL tmr_clr_vs_set tval=%0d ti=%0b required 0 0", tval, ti_pend);
    end
    // En = 0 freezes the loaded value.
    tcfg_we = 1'b1; tcfg_wdata = 32'h0000_0014;
    cyc();
    tcfg_we = 1'b0;
    cyc(); cyc(); cyc();
    @(negedge clk);
    checks++;
    if (tval !== 32'd20 || ti_pend !== 1'b0) begin
      errors++;
      $display("FAIL tmr_freeze tval=%0d ti=%0b required 20 0", tval, ti_pend);
    end
  endtask

  task automatic test_reset_in_wait();
    cyc();
    wb_valid = 1'b1; wb_pc = 32'h1c00_0500; wb_exc = 5'b01000;
    push_exp(1'b0, 6'h0C, 32'h1c00_0500);
    cyc();
    wb_valid = 1'b0; wb_exc = '0;
    cyc();
    @(negedge clk);
    checks++;
    if (redirect_valid !== 1'b1 || flush !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_entry rv=%0b flush=%0b required 1 1", redirect_valid, flush);
    end
    cyc();
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if ({exc_signal, ertn_signal, flush, redirect_valid, ti_pend} !== 5'b0 ||
        exc_ecode !== 6'h0 || exc_pc !== 32'h0 || tval !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL rst_wait_out ctrl=%b ecode=%h pc=%h tval=%h required 0 0 0 ffffffff",
               {exc_signal, ertn_signal, flush, redirect_valid, ti_pend}, exc_ecode, exc_pc, tval);
    end
    // Back in RUN: a new exception pulses immediately.
    push_exp(1'b0, 6'h0B, 32'h1c00_0600);
    fire(32'h1c00_0600, 5'b00100, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_drain pending=%0d required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_sys();
    test_priority();
    test_ertn_wait();
    test_int_mask();
    test_timer();
    test_reset_in_wait();
    cyc(); cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
